// File: rtl/range_stream_pkg.sv
// Shared types and constants for the range-finder stream driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package range_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_BODY,
        ST_LAST,
        ST_CHECK,
        ST_REPORT
    } state_t;

    localparam int DEFAULT_WIDTH = 10;

    // Shortest legal burst: one go word plus one finish word.
    localparam int MIN_LEN = 2;

    // Fibonacci feedback taps for a maximal-length sequence of the given width.
    // Bit k set means register bit k feeds the XOR (polynomial term x^(k+1)).
    function automatic logic [15:0] tap_mask(input int width);
        logic [15:0] m;
        case (width)
            8:       m = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       m = 16'h0110;  // x^9+x^5+1
            10:      m = 16'h0240;  // x^10+x^7+1
            11:      m = 16'h0500;  // x^11+x^9+1
            12:      m = 16'h0E08;  // x^12+x^11+x^10+x^4+1
            13:      m = 16'h1C80;  // x^13+x^12+x^11+x^8+1
            14:      m = 16'h3802;  // x^14+x^13+x^12+x^2+1
            15:      m = 16'h6000;  // x^15+x^14+1
            16:      m = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: m = 16'h0240;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/range_lfsr.sv
// Pseudo-random word source for burst bodies; never reaches the all-zero state.
// Latency: value updates on the clock edge where advance is high.
// Backpressure: none; advance is a plain step enable.
module range_lfsr
    import range_stream_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(10'h2A5)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [15:0]      MASK_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] MASK      = MASK_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Shift left, feedback XOR of tapped bits enters at the LSB.
    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = {value_q[WIDTH-2:0], ^(value_q & MASK)};
        end
    end

    // Register with seed on reset; a nonzero seed keeps the sequence out of zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/range_stream_driver.sv
// Self-test transmitter: sends a framed lo..hi burst, then grades the receiver's range/error result.
// Latency: go one cycle after handshake; done len+2 cycles after go (illegal command: done 2 cycles after handshake).
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped. Optional RANGE_STREAM_ERR_INJECT_EN adds cmd_inject.
module range_stream_driver
    import range_stream_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               LEN_W     = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(10'h2A5)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic [LEN_W-1:0] cmd_len,
`ifdef RANGE_STREAM_ERR_INJECT_EN
    input  logic             cmd_inject,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    input  logic [WIDTH-1:0] range_in,
    input  logic             error_in,
    output logic             done,
    output logic             pass,
    output logic             cmd_err,
    output logic [WIDTH-1:0] result_range
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             inj_q, inj_d, bad_q, bad_d;
    logic [WIDTH-1:0] cap_range_q, cap_range_d;
    logic             cap_err_q, cap_err_d;
    logic [WIDTH-1:0] data_out_q, data_out_d, result_range_q, result_range_d;
    logic             go_q, go_d, finish_q, finish_d;
    logic             done_q, done_d, pass_q, pass_d, cmd_err_q, cmd_err_d;
    logic             lfsr_adv;
    logic [WIDTH-1:0] lfsr_val, lfsr_clip;
    logic             inject_in, range_ok;

    range_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

`ifdef RANGE_STREAM_ERR_INJECT_EN
    assign inject_in = cmd_inject;
    // An injected violation must be flagged by the receiver; range is irrelevant.
    assign range_ok  = inj_q ? cap_err_q : ((cap_range_q == (hi_q - lo_q)) && !cap_err_q);
`else
    assign inject_in = 1'b0;
    assign range_ok  = (cap_range_q == (hi_q - lo_q)) && !cap_err_q;
`endif

    // Body words are the generator value clamped into the commanded window.
    assign lfsr_clip = (lfsr_val > hi_q) ? hi_q : ((lfsr_val < lo_q) ? lo_q : lfsr_val);

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d        = state_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        cnt_d          = cnt_q;
        inj_d          = inj_q;
        bad_d          = bad_q;
        cap_range_d    = cap_range_q;
        cap_err_d      = cap_err_q;
        result_range_d = result_range_q;
        data_out_d     = '0;
        go_d           = 1'b0;
        finish_d       = 1'b0;
        done_d         = 1'b0;
        pass_d         = 1'b0;
        cmd_err_d      = 1'b0;
        lfsr_adv       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    lo_d  = cmd_lo;
                    hi_d  = cmd_hi;
                    inj_d = inject_in;
                    if ((cmd_len < LEN_W'(MIN_LEN)) || (cmd_lo > cmd_hi)) begin
                        bad_d   = 1'b1;
                        state_d = ST_REPORT;
                    end else begin
                        bad_d      = 1'b0;
                        state_d    = ST_FIRST;
                        data_out_d = cmd_lo;
                        go_d       = 1'b1;
                        cnt_d      = cmd_len - LEN_W'(MIN_LEN);
                    end
                end
            end
            ST_FIRST, ST_BODY: begin
                // cnt holds body words still to send after the current word.
                go_d = inj_q && (state_q == ST_FIRST);
                if (cnt_q == '0) begin
                    state_d    = ST_LAST;
                    data_out_d = hi_q;
                    finish_d   = 1'b1;
                end else begin
                    state_d    = ST_BODY;
                    data_out_d = lfsr_clip;
                    lfsr_adv   = 1'b1;
                    cnt_d      = cnt_q - LEN_W'(1);
                end
            end
            ST_LAST: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Receiver result is valid the cycle after it saw finish.
                cap_range_d = range_in;
                cap_err_d   = error_in;
                state_d     = ST_REPORT;
            end
            ST_REPORT: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (bad_q) begin
                    cmd_err_d = 1'b1;
                end else begin
                    pass_d         = range_ok;
                    result_range_d = cap_range_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single state/output register; async reset aborts any burst in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            lo_q           <= '0;
            hi_q           <= '0;
            cnt_q          <= '0;
            inj_q          <= 1'b0;
            bad_q          <= 1'b0;
            cap_range_q    <= '0;
            cap_err_q      <= 1'b0;
            result_range_q <= '0;
            data_out_q     <= '0;
            go_q           <= 1'b0;
            finish_q       <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            cnt_q          <= cnt_d;
            inj_q          <= inj_d;
            bad_q          <= bad_d;
            cap_range_q    <= cap_range_d;
            cap_err_q      <= cap_err_d;
            result_range_q <= result_range_d;
            data_out_q     <= data_out_d;
            go_q           <= go_d;
            finish_q       <= finish_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign data_out     = data_out_q;
    assign go           = go_q;
    assign finish       = finish_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign cmd_err      = cmd_err_q;
    assign result_range = result_range_q;

endmodule

// File: tb/tb_range_stream_driver.sv
// Bench for range_stream_driver: directed table, reset-abort sequence, randomized commands.
// Latency: checks go one cycle after handshake and done len+2 cycles after go.
// Backpressure: offers a legal command while busy and expects it to be dropped.
module tb_range_stream_driver;

    localparam logic [9:0] SEED = 10'h2A5;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_lo, cmd_hi;
    logic [7:0] cmd_len;
`ifdef RANGE_STREAM_ERR_INJECT_EN
    logic       cmd_inject;
`endif
    logic [9:0] data_out;
    logic       go, finish;
    logic [9:0] range_in;
    logic       error_in;
    logic       done, pass, cmd_err;
    logic [9:0] result_range;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference generator state: x^10+x^7+1, one step per body word emitted.
    logic [9:0] m_lfsr;

    always #5 clock = ~clock;

    range_stream_driver dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_lo       (cmd_lo),
        .cmd_hi       (cmd_hi),
        .cmd_len      (cmd_len),
`ifdef RANGE_STREAM_ERR_INJECT_EN
        .cmd_inject   (cmd_inject),
`endif
        .data_out     (data_out),
        .go           (go),
        .finish       (finish),
        .range_in     (range_in),
        .error_in     (error_in),
        .done         (done),
        .pass         (pass),
        .cmd_err      (cmd_err),
        .result_range (result_range)
    );

    typedef struct {
        logic [9:0] lo;
        logic [9:0] hi;
        logic [7:0] len;
        logic       inj;
        logic [9:0] rng;
        logic       err;
        logic       exp_pass;
        logic       exp_cerr;
    } vec_t;

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic logic [9:0] clip(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [9:0] lo, input logic [9:0] hi,
                           input logic [7:0] len, input logic inj, input logic [9:0] rng,
                           input logic err, input logic exp_pass, input logic exp_cerr);
        logic [9:0] words[$];
        logic       gos[$];
        logic       fins[$];
        int         cyc, go_cyc, fin_cyc, done_cyc, stray;
        bit         in_burst, got_done;
        logic       d_pass, d_cerr;
        logic [9:0] d_range, exp_w;
        @(negedge clock);
        check({tag, ".ready_idle"}, cmd_ready, 1);
        range_in  = rng ^ 10'h3FF;
        error_in  = ~err;
        cmd_lo    = lo;
        cmd_hi    = hi;
        cmd_len   = len;
        cmd_valid = 1'b1;
`ifdef RANGE_STREAM_ERR_INJECT_EN
        cmd_inject = inj;
`endif
        @(posedge clock);
        #1;
        // A legal command left pending while busy must be ignored.
        cmd_lo  = 10'd0;
        cmd_hi  = 10'h3FF;
        cmd_len = 8'd4;
`ifdef RANGE_STREAM_ERR_INJECT_EN
        cmd_inject = ~inj;
`endif
        cyc = 0; go_cyc = -1; fin_cyc = -1; done_cyc = -1; stray = 0;
        in_burst = 0; got_done = 0;
        d_pass = 0; d_cerr = 0; d_range = 0;
        while (!got_done && cyc < int'(len) + 40) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) check({tag, ".ready_busy"}, cmd_ready, 0);
            if (go && !in_burst && words.size() == 0) begin
                in_burst = 1;
                go_cyc   = cyc;
            end
            if (in_burst) begin
                words.push_back(data_out);
                gos.push_back(go);
                fins.push_back(finish);
                if (finish) begin
                    in_burst = 0;
                    fin_cyc  = cyc;
                end
            end else if (go || finish || data_out != 10'd0) begin
                stray++;
            end
            // Receiver answers only in the cycle after finish.
            if (fin_cyc > 0 && cyc == fin_cyc + 1) begin
                range_in = rng;
                error_in = err;
            end else begin
                range_in = rng ^ 10'h3FF;
                error_in = ~err;
            end
            if (done) begin
                got_done  = 1;
                done_cyc  = cyc;
                d_pass    = pass;
                d_cerr    = cmd_err;
                d_range   = result_range;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check({tag, ".done_seen"}, got_done, 1);
        check({tag, ".stray_outputs"}, stray, 0);
        check({tag, ".cmd_err"}, d_cerr, exp_cerr);
        check({tag, ".pass"}, d_pass, exp_pass);
        if (exp_cerr) begin
            check({tag, ".no_words"}, words.size(), 0);
            check({tag, ".err_done_lat"}, done_cyc, 2);
        end else begin
            check({tag, ".nwords"}, words.size(), len);
            check({tag, ".go_lat"}, go_cyc, 1);
            check({tag, ".done_lat"}, done_cyc - go_cyc, int'(len) + 2);
            check({tag, ".result_range"}, d_range, rng);
            for (int i = 0; i < int'(len); i++) begin
                if (i == 0) exp_w = lo;
                else if (i == int'(len) - 1) exp_w = hi;
                else begin
                    exp_w  = clip(m_lfsr, lo, hi);
                    m_lfsr = lfsr_next(m_lfsr);
                end
                if (i < words.size()) begin
                    check({tag, ".word"}, words[i], exp_w);
                    check({tag, ".go_flag"}, gos[i], (i == 0) || (inj && i == 1));
                    check({tag, ".finish_flag"}, fins[i], i == int'(len) - 1);
                end
            end
        end
        @(negedge clock);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        vec_t       tbl[$];
        logic [9:0] lo, hi, rng, exp_w;
        logic [7:0] len;
        logic       inj, err, bad, ep;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_lo    = '0;
        cmd_hi    = '0;
        cmd_len   = '0;
`ifdef RANGE_STREAM_ERR_INJECT_EN
        cmd_inject = 1'b0;
`endif
        range_in  = '0;
        error_in  = 1'b0;
        m_lfsr    = SEED;

        #12;
        check("rst.ready", cmd_ready, 1);
        check("rst.data", data_out, 0);
        check("rst.go", go, 0);
        check("rst.finish", finish, 0);
        check("rst.done", done, 0);
        check("rst.pass", pass, 0);
        check("rst.cmd_err", cmd_err, 0);
        check("rst.range", result_range, 0);
        @(negedge clock);
        reset = 1'b1;

        //           lo       hi       len    inj   rng       err   pass  cerr
        tbl.push_back('{10'd100, 10'd600, 8'd8, 1'b0, 10'd500,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{10'd37,  10'd37,  8'd2, 1'b0, 10'd0,    1'b0, 1'b1, 1'b0});
        tbl.push_back('{10'd100, 10'd600, 8'd1, 1'b0, 10'd500,  1'b0, 1'b0, 1'b1});
        tbl.push_back('{10'd700, 10'd200, 8'd8, 1'b0, 10'd500,  1'b0, 1'b0, 1'b1});
        tbl.push_back('{10'd100, 10'd600, 8'd8, 1'b0, 10'd499,  1'b0, 1'b0, 1'b0});
        tbl.push_back('{10'd100, 10'd600, 8'd8, 1'b0, 10'd500,  1'b1, 1'b0, 1'b0});
        tbl.push_back('{10'd0,   10'd1023,8'd3, 1'b0, 10'd1023, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{10'd5,   10'd5,   8'd0, 1'b0, 10'd0,    1'b0, 1'b0, 1'b1});
`ifdef RANGE_STREAM_ERR_INJECT_EN
        tbl.push_back('{10'd100, 10'd600, 8'd5, 1'b1, 10'd0,    1'b1, 1'b1, 1'b0});
        tbl.push_back('{10'd100, 10'd600, 8'd5, 1'b1, 10'd500,  1'b0, 1'b0, 1'b0});
`endif
        for (int t = 0; t < tbl.size(); t++) begin
            run_cmd($sformatf("vec%0d", t), tbl[t].lo, tbl[t].hi, tbl[t].len, tbl[t].inj,
                    tbl[t].rng, tbl[t].err, tbl[t].exp_pass, tbl[t].exp_cerr);
        end

        // Reset lands on word 4 of a 20-word burst.
        @(negedge clock);
        cmd_lo = 10'd100; cmd_hi = 10'd600; cmd_len = 8'd20; cmd_valid = 1'b1;
`ifdef RANGE_STREAM_ERR_INJECT_EN
        cmd_inject = 1'b0;
`endif
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            if (c == 1) begin
                check("abort.first_word", data_out, 100);
                check("abort.first_go", go, 1);
            end else begin
                exp_w  = clip(m_lfsr, 10'd100, 10'd600);
                m_lfsr = lfsr_next(m_lfsr);
                check("abort.body_word", data_out, exp_w);
            end
        end
        reset = 1'b0;
        #1;
        check("abort.data", data_out, 0);
        check("abort.go", go, 0);
        check("abort.finish", finish, 0);
        check("abort.done", done, 0);
        check("abort.range", result_range, 0);
        m_lfsr = SEED;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort.ready", cmd_ready, 1);
        run_cmd("after_abort", 10'd100, 10'd600, 8'd8, 1'b0, 10'd500, 1'b0, 1'b1, 1'b0);

        // Randomized commands graded by the protocol rules.
        for (int r = 0; r < 40; r++) begin
            lo  = 10'($urandom_range(0, 1023));
            hi  = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(int'(lo), 1023))
                                              : 10'($urandom_range(0, 1023));
            len = 8'($urandom_range(0, 12));
`ifdef RANGE_STREAM_ERR_INJECT_EN
            inj = 1'($urandom_range(0, 1));
`else
            inj = 1'b0;
`endif
            rng = ($urandom_range(0, 1) != 0) ? (hi - lo) : 10'($urandom_range(0, 1023));
            err = ($urandom_range(0, 3) == 0);
            bad = (len < 8'd2) || (lo > hi);
            if (bad) ep = 1'b0;
            else if (inj) ep = err;
            else ep = (rng == hi - lo) && !err;
            run_cmd($sformatf("rand%0d", r), lo, hi, len, inj, rng, err, ep, bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
